// File: rtl/lut_bank_if.sv
// Config/evaluate bundle for lut_bank: serial table load plus eval request/result.
// The master side drives requests; the slave side (lut_bank) returns done/ready/results.
interface lut_bank_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
);
  logic              cfg_start;
  logic              cfg_valid;
  logic              cfg_bit;
  logic              cfg_done;
  logic              in_valid;
  logic [N_IN-1:0]   in_vec;
  logic              in_ready;
  logic              out_valid;
  logic [N_OUT-1:0]  out_vec;

  modport master (
    output cfg_start, cfg_valid, cfg_bit, in_valid, in_vec,
    input  cfg_done, in_ready, out_valid, out_vec
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_bit, in_valid, in_vec,
    output cfg_done, in_ready, out_valid, out_vec
  );
endinterface

// File: rtl/lut_bank.sv
// Bank of N_OUT programmable N_IN-input truth tables, loaded serially index 0 first.
// Evaluation latency 1 cycle, one per cycle; no output backpressure, in_ready only in READY.
module lut_bank #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  lut_bank_if.slave bus
);

  localparam int DEPTH = 1 << N_IN;
  localparam int TBITS = N_OUT * DEPTH;
  localparam int CW    = $clog2(TBITS + 1);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] READY = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [TBITS-1:0] tbl;
  logic [DEPTH-1:0] row [N_OUT];
  logic [N_OUT-1:0] lookup;
  logic             cap;
  logic             last;
  logic             accept;

  assign bus.in_ready = (state == READY);
  assign accept       = bus.in_valid & bus.in_ready;
  // cfg_valid is ignored in the cfg_start cycle so a restart always begins at index 0
  assign cap          = (state == LOAD) & bus.cfg_valid & ~bus.cfg_start;
  assign last         = cap & (cnt == CW'(TBITS - 1));

  for (genvar o = 0; o < N_OUT; o++) begin : g_row
    assign row[o]    = tbl[o*DEPTH +: DEPTH];
    assign lookup[o] = row[o][bus.in_vec];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      cnt          <= '0;
      bus.cfg_done <= 1'b0;
    end else begin
      bus.cfg_done <= last;
      if (bus.cfg_start) begin
        state <= LOAD;
        cnt   <= '0;
      end else if (cap) begin
        cnt <= cnt + CW'(1);
        if (last) begin
          state <= READY;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl <= '0;
    end else if (cap) begin
      for (int k = 0; k < TBITS; k++) begin
        if (cnt == CW'(k)) begin
          tbl[k] <= bus.cfg_bit;
        end
      end
    end
  end

  // Reads the pre-update table, so an eval coinciding with cfg_start sees the old contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_vec   <= '0;
    end else begin
      bus.out_valid <= accept;
      if (accept) begin
        bus.out_vec <= lookup;
      end
    end
  end

endmodule

// File: tb/tb_lut_bank.sv
// Directed bench for lut_bank (N_IN=4, N_OUT=2): load, evaluate, pause, restart, reset, overlap.
module tb_lut_bank;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  lut_bank_if #(.N_IN(4), .N_OUT(2)) bus ();

  lut_bank #(.N_IN(4), .N_OUT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] TBL_A = {16'hADA6, 16'hF81A};
  localparam logic [31:0] TBL_1 = 32'hFFFF_FFFF;

  int early_done;
  int ready_seen;
  int last_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] model(input logic [31:0] t, input int m);
    logic [1:0] r;
    r[0] = t[m];
    r[1] = t[16 + m];
    return r;
  endfunction

  // Sends cfg_start then up to stop_at bits; optional idle gap after bit pause_at.
  task automatic do_load(input logic [31:0] b, input int pause_at, input int pause_len,
                         input int stop_at);
    bus.cfg_start = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_bit   = ~b[0];
    tick();
    bus.cfg_start = 1'b0;
    for (int i = 0; i < stop_at; i++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_bit   = b[i];
      tick();
      if (i == 31) last_done = int'(bus.cfg_done);
      else if (bus.cfg_done) early_done++;
      if (i < 31 && bus.in_ready) ready_seen++;
      if (i == pause_at) begin
        bus.cfg_valid = 1'b0;
        for (int p = 0; p < pause_len; p++) begin
          tick();
          if (bus.cfg_done) early_done++;
          if (bus.in_ready) ready_seen++;
        end
      end
    end
    bus.cfg_valid = 1'b0;
  endtask

  task automatic check_full_load(input string tag);
    chk({tag, "_done_last"}, last_done, 1);
    chk({tag, "_no_early_done"}, early_done, 0);
    chk({tag, "_ready_low_load"}, ready_seen, 0);
    chk({tag, "_ready_after"}, bus.in_ready, 1'b1);
    tick();
    chk({tag, "_done_single"}, bus.cfg_done, 1'b0);
  endtask

  task automatic eval(input int m, input logic [1:0] exp);
    bus.in_valid = 1'b1;
    bus.in_vec   = 4'(m);
    tick();
    bus.in_valid = 1'b0;
    chk($sformatf("eval%0d_valid", m), bus.out_valid, 1'b1);
    chk($sformatf("eval%0d_vec", m), bus.out_vec, exp);
    tick();
    chk($sformatf("eval%0d_single", m), bus.out_valid, 1'b0);
  endtask

  task automatic sweep(input logic [31:0] t, input string tag);
    for (int m = 0; m < 16; m++) begin
      bus.in_valid = 1'b1;
      bus.in_vec   = 4'(m);
      tick();
      chk($sformatf("%s_v%0d", tag, m), bus.out_valid, 1'b1);
      chk($sformatf("%s_o%0d", tag, m), bus.out_vec, model(t, m));
    end
    bus.in_valid = 1'b0;
    tick();
    chk({tag, "_end_valid"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n         = 1'b0;
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_bit   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    tick();
    tick();
    chk("rst_cfg_done", bus.cfg_done, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_vec", bus.out_vec, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Evaluation attempted while EMPTY must be refused
    bus.in_valid = 1'b1;
    bus.in_vec   = 4'd3;
    tick();
    bus.in_valid = 1'b0;
    chk("empty_in_ready", bus.in_ready, 1'b0);
    chk("empty_out_valid", bus.out_valid, 1'b0);

    early_done = 0; ready_seen = 0; last_done = 0;
    do_load(TBL_A, -1, 0, 32);
    check_full_load("loadA");
    eval(3, 2'b01);
    eval(13, 2'b11);
    sweep(TBL_A, "b2bA");

    // Restart after 20 bits, then all-ones table
    early_done = 0; ready_seen = 0; last_done = 0;
    do_load(TBL_A, -1, 0, 20);
    chk("restart_partial_done", early_done, 0);
    do_load(TBL_1, -1, 0, 32);
    check_full_load("ones");
    eval(0, 2'b11);
    eval(7, 2'b11);
    eval(15, 2'b11);

    // Paused load must give the same table as an unpaused one
    early_done = 0; ready_seen = 0; last_done = 0;
    do_load(TBL_A, 10, 5, 32);
    check_full_load("pause");
    sweep(TBL_A, "b2bP");

    // Evaluation and reload in the same cycle use the old table
    bus.in_valid  = 1'b1;
    bus.in_vec    = 4'd3;
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    chk("ovl_out_valid", bus.out_valid, 1'b1);
    chk("ovl_out_vec", bus.out_vec, 2'b01);
    chk("ovl_ready_drop", bus.in_ready, 1'b0);
    bus.in_vec = 4'd13;
    tick();
    bus.in_valid = 1'b0;
    chk("ovl_no_accept", bus.out_valid, 1'b0);
    chk("ovl_vec_hold", bus.out_vec, 2'b01);

    // Reset mid-load at bit 12
    early_done = 0; ready_seen = 0; last_done = 0;
    do_load(TBL_1, -1, 0, 12);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_vec", bus.out_vec, 2'b00);
    chk("mid_rst_in_ready", bus.in_ready, 1'b0);
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_cfg_done", bus.cfg_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_vec   = 4'd5;
    early_done = 0; ready_seen = 0;
    for (int i = 0; i < 34; i++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_bit   = 1'b1;
      tick();
      if (bus.out_valid) early_done++;
      if (bus.in_ready || bus.cfg_done) ready_seen++;
    end
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 1'b0;
    chk("post_rst_no_out", early_done, 0);
    chk("post_rst_empty", ready_seen, 0);
    chk("post_rst_out_vec", bus.out_vec, 2'b00);

    // Full reload after the aborted one brings the bank back
    early_done = 0; ready_seen = 0; last_done = 0;
    do_load(TBL_A, -1, 0, 32);
    check_full_load("reload");
    eval(13, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
